// File: rtl/mem_port_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, transaction owner, byte-enable constant.
package mem_port_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      IF   = 2'd1,
      MEM  = 2'd2
   } owner_t;

   localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating response watchdog: counts enabled cycles since clear, flags expiry at TIMEOUT_CYCLES-1.
module bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_wd;
         assign unused_wd = &{1'b0, clk, rst, clear, enable};
         assign expired   = 1'b0;
      end else begin : g_on
         localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
         logic [CW-1:0] count;

         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               count <= '0;
            end else if (clear) begin
               count <= '0;
            end else if (enable && !expired) begin
               count <= count + 1'b1;
            end
         end

         assign expired = (count == CW'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and MEM stage, one bus transaction at a time.
module mem_port_arbiter
   import mem_port_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [DATA_WIDTH-1:0] if_addr,
   input  logic                  flush_f,
   output logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [3:0]            mem_be,
   output logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_err,
   output logic                  stall_f,
   output logic                  stall_m,
   output logic                  bus_valid,
   output logic                  bus_we,
   output logic [DATA_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   output logic [3:0]            bus_be,
   input  logic                  bus_ready,
   input  logic                  bus_rvalid,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   arb_state_t            state, state_nx;
   owner_t                owner;
   logic                  discard;
   logic                  err;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  accept;
   logic                  expired;

   assign accept = (state == ADDR) && bus_ready;

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .enable  (state == RESP),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // NOTE: next-state gets a default before the case so no path can infer a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (mem_req || (if_req && !flush_f)) state_nx = ADDR;
         ADDR: if (bus_ready) state_nx = RESP;
         RESP: if (bus_rvalid || expired) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Payload is latched at grant and held until the next grant, keeping it stable while bus_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= NONE;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
         rdata_q   <= '0;
         err       <= 1'b0;
         discard   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (mem_req) begin
                  owner     <= MEM;
                  bus_we    <= mem_we;
                  bus_addr  <= mem_addr;
                  bus_wdata <= mem_wdata;
                  bus_be    <= mem_be;
                  err       <= 1'b0;
                  discard   <= 1'b0;
               end else if (if_req && !flush_f) begin
                  owner     <= IF;
                  bus_we    <= 1'b0;
                  bus_addr  <= if_addr;
                  bus_wdata <= '0;
                  bus_be    <= BE_FULL;
                  err       <= 1'b0;
                  discard   <= 1'b0;
               end
            end
            RESP: begin
               if (bus_rvalid) begin
                  rdata_q <= bus_we ? '0 : bus_rdata;
                  err     <= 1'b0;
               end else if (expired) begin
                  rdata_q <= '0;
                  err     <= 1'b1;
               end
            end
            DONE:    owner <= NONE;
            default: ;
         endcase
         if ((state != IDLE) && (owner == IF) && flush_f) discard <= 1'b1;
      end
   end

   assign mem_ready = (state == DONE) && (owner == MEM);
   assign if_ready  = (state == DONE) && (owner == IF) && !discard && !flush_f;
   assign mem_rdata = rdata_q;
   assign if_rdata  = rdata_q;
   assign mem_err   = err && (mem_ready || if_ready);
   assign bus_valid = (state == ADDR);
   assign stall_f   = rst && if_req && !if_ready;
   assign stall_m   = rst && mem_req && !mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized transactions against a timeline model.
module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, flush_f, if_ready;
   logic [DW-1:0] if_addr, if_rdata;
   logic          mem_req, mem_we, mem_ready, mem_err;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]    mem_be;
   logic          stall_f, stall_m;
   logic          bus_valid, bus_we, bus_ready, bus_rvalid;
   logic [DW-1:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]    bus_be;

   int n_checks = 0;
   int n_err    = 0;

   mem_port_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .flush_f(flush_f),
      .if_ready(if_ready), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .stall_f(stall_f), .stall_m(stall_m),
      .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one granted transaction from its IDLE grant cycle (c=0) to DONE.
   // rd: ADDR cycles before bus_ready; vd: RESP cycles before bus_rvalid (>=TO means hung).
   task automatic do_txn(input bit is_mem, input int rd, input int vd, input int flush_at,
                         input logic [31:0] rsp, input bit spur);
      int          k, total;
      bit          tout, disc, ev, e_mr, e_ir, e_we;
      logic [31:0] e_addr, e_data;
      logic [3:0]  e_be;
      tout   = (vd >= TO);
      k      = tout ? TO - 1 : vd;
      total  = 3 + rd + k;
      disc   = !is_mem && (flush_at >= 1) && (flush_at <= total);
      e_addr = is_mem ? mem_addr : if_addr;
      e_we   = is_mem && mem_we;
      e_be   = is_mem ? mem_be : 4'hF;
      e_data = (tout || e_we) ? 32'h0 : rsp;
      for (int c = 0; c <= total; c++) begin
         bus_ready  = (c == 1 + rd);
         bus_rvalid = (!tout && (c == 2 + rd + vd)) || (spur && (c <= 1 + rd));
         bus_rdata  = (c == 2 + rd + vd) ? rsp : $urandom;
         flush_f    = (c == flush_at);
         @(negedge clk);
         ev   = (c >= 1) && (c <= 1 + rd);
         e_mr = is_mem && (c == total);
         e_ir = !is_mem && !disc && (c == total);
         check("bus_valid", bus_valid, ev);
         if (ev) begin
            check("bus_addr", bus_addr, e_addr);
            check("bus_we", bus_we, e_we);
            check("bus_be", bus_be, e_be);
            if (is_mem) check("bus_wdata", bus_wdata, mem_wdata);
         end
         check("mem_ready", mem_ready, e_mr);
         check("if_ready", if_ready, e_ir);
         check("mem_err", mem_err, (e_mr || e_ir) && tout);
         if (e_mr) check("mem_rdata", mem_rdata, e_data);
         if (e_ir) check("if_rdata", if_rdata, e_data);
         check("stall_m", stall_m, mem_req && !e_mr);
         check("stall_f", stall_f, if_req && !e_ir);
         tick();
      end
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      flush_f    = 1'b0;
   endtask

   initial begin
      int scen, rd, vd, fa;
      rst = 1'b0;
      if_req = 1'b0; if_addr = '0; flush_f = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_bus_valid", bus_valid, 1'b0);
      check("rst_mem_ready", mem_ready, 1'b0);
      check("rst_if_ready", if_ready, 1'b0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_mem_err", mem_err, 1'b0);
      tick();
      rst = 1'b1;
      tick();

      // Load with minimum latency
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_be = 4'hF; mem_wdata = '0;
      do_txn(1'b1, 0, 0, -1, 32'hDEADBEEF, 1'b0);
      mem_req = 1'b0;

      // Simultaneous requests: store first, then fetch
      if_req = 1'b1; if_addr = 32'h0;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hCAFE0001; mem_be = 4'b0011;
      do_txn(1'b1, 0, 0, -1, 32'h55AA55AA, 1'b0);
      mem_req = 1'b0; mem_we = 1'b0;
      do_txn(1'b0, 0, 0, -1, 32'h00000013, 1'b0);
      if_req = 1'b0;

      // Flushed fetch, then redirected fetch
      if_req = 1'b1; if_addr = 32'h40;
      do_txn(1'b0, 0, 0, 2, 32'h13, 1'b0);
      if_addr = 32'h80;
      do_txn(1'b0, 0, 1, -1, 32'h93, 1'b0);
      if_req = 1'b0;

      // Watchdog timeout and the last in-time response
      mem_req = 1'b1; mem_addr = 32'h400; mem_be = 4'hF;
      do_txn(1'b1, 0, 10, -1, 32'h12345678, 1'b0);
      do_txn(1'b1, 1, TO - 1, -1, 32'h87654321, 1'b1);
      mem_req = 1'b0;

      // Reset during ADDR, late response afterwards
      mem_req = 1'b1; mem_addr = 32'h300;
      tick();
      @(negedge clk);
      check("pre_rst_valid", bus_valid, 1'b1);
      #1 rst = 1'b0;
      #1;
      check("rst_addr_valid", bus_valid, 1'b0);
      check("rst_addr_stall_m", stall_m, 1'b0);
      mem_req = 1'b0;
      tick();
      rst = 1'b1;
      bus_rvalid = 1'b1; bus_rdata = 32'hBADBAD00;
      @(negedge clk);
      check("late_rvalid_valid", bus_valid, 1'b0);
      check("late_rvalid_ready", mem_ready, 1'b0);
      tick();
      bus_rvalid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_ready", mem_ready || if_ready, 1'b0);
         tick();
      end
      mem_req = 1'b1; mem_addr = 32'h304;
      do_txn(1'b1, 0, 0, -1, 32'h0BADF00D, 1'b0);
      mem_req = 1'b0;

      // Long bus_ready stall: payload stable, watchdog idle
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_wdata = 32'hA5A5A5A5; mem_be = 4'b1100;
      do_txn(1'b1, 10, TO - 1, -1, 32'hFFFFFFFF, 1'b0);
      mem_req = 1'b0; mem_we = 1'b0;

      // Randomized mix
      for (int i = 0; i < 40; i++) begin
         scen = $urandom_range(0, 2);
         mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom; mem_be = 4'($urandom);
         if_addr = $urandom;
         mem_req = (scen != 1);
         if_req  = (scen != 0);
         if (mem_req) begin
            rd = $urandom_range(0, 3); vd = $urandom_range(0, 5);
            do_txn(1'b1, rd, vd, -1, $urandom, 1'($urandom));
            mem_req = 1'b0;
         end
         if (if_req) begin
            rd = $urandom_range(0, 3); vd = $urandom_range(0, 5);
            fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : -1;
            do_txn(1'b0, rd, vd, fa, $urandom, 1'($urandom));
            if_req = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
